// File: rtl/iob_ila_pattern_gen.sv
// Pattern generator: plays a preloaded sample buffer out on signal_o,
// optionally waiting for a masked trigger, with a per-sample hold and loop mode.
module iob_ila_pattern_gen #(
  parameter int unsigned SIGNAL_W  = 32,
  parameter int unsigned BUFFER_W  = 10,
  parameter int unsigned TRIGGER_W = 1,
  parameter int unsigned HOLD_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic                 wr_en_i,
  input  logic [BUFFER_W-1:0]  wr_addr_i,
  input  logic [SIGNAL_W-1:0]  wr_data_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [BUFFER_W:0]    length_i,
  input  logic [HOLD_W-1:0]    hold_i,
  input  logic                 loop_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] trig_mask_i,
  output logic [SIGNAL_W-1:0]  signal_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [BUFFER_W-1:0]  index_o
);

  localparam int unsigned DEPTH = 1 << BUFFER_W;
  localparam int unsigned LEN_W = BUFFER_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [SIGNAL_W-1:0]  mem_q [DEPTH];

  state_t               state_q;
  logic [BUFFER_W-1:0]  rd_addr_q;
  logic [BUFFER_W-1:0]  last_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic                 loop_q;
  logic [TRIGGER_W-1:0] mask_q;
  logic                 fin_q;
  logic [SIGNAL_W-1:0]  signal_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic [BUFFER_W-1:0]  index_q;

  logic start_ok_c;
  logic trig_hit_c;
  logic last_c;
  logic hold_end_c;

  assign start_ok_c = start_i && (length_i != '0) && (length_i <= LEN_W'(DEPTH));
  assign trig_hit_c = |(trigger_i & mask_q);
  assign last_c     = (rd_addr_q == last_q);
  assign hold_end_c = (hold_cnt_q == hold_q);

  // Pattern buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Playback FSM, read pointer, hold counter and registered outputs.
  // fin_q keeps PLAY alive for the last sample's final output cycle,
  // since the output lags the read address by one cycle.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      last_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      loop_q     <= 1'b0;
      mask_q     <= '0;
      fin_q      <= 1'b0;
      signal_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      index_q    <= '0;
    end else if (cke_i) begin
      if (stop_i) begin
        state_q <= S_IDLE;
        fin_q   <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_ok_c) begin
              last_q     <= BUFFER_W'(length_i - LEN_W'(1));
              hold_q     <= hold_i;
              loop_q     <= loop_i;
              mask_q     <= trig_mask_i;
              rd_addr_q  <= '0;
              hold_cnt_q <= '0;
              fin_q      <= 1'b0;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              state_q    <= (trig_mask_i != '0) ? S_ARMED : S_PLAY;
            end
          end
          S_ARMED: begin
            if (trig_hit_c) begin
              state_q <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (fin_q) begin
              fin_q   <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              if (hold_cnt_q == '0) begin
                signal_q <= mem_q[rd_addr_q];
                index_q  <= rd_addr_q;
                valid_q  <= 1'b1;
              end
              if (hold_end_c) begin
                hold_cnt_q <= '0;
                if (last_c) begin
                  if (loop_q) begin
                    rd_addr_q <= '0;
                  end else begin
                    fin_q <= 1'b1;
                  end
                end else begin
                  rd_addr_q <= rd_addr_q + BUFFER_W'(1);
                end
              end else begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign signal_o = signal_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign index_o  = index_q;

endmodule

// File: tb/tb_iob_ila_pattern_gen.sv
// Directed bench for iob_ila_pattern_gen with BUFFER_W=3, TRIGGER_W=2.
module tb_iob_ila_pattern_gen;

  logic        clk_i;
  logic        arst_i;
  logic        cke_i;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        start_i;
  logic        stop_i;
  logic [3:0]  length_i;
  logic [15:0] hold_i;
  logic        loop_i;
  logic [1:0]  trigger_i;
  logic [1:0]  trig_mask_i;
  logic [31:0] signal_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  index_o;

  int n_checks;
  int n_errors;
  logic [31:0] exp_mem [8];
  bit found;

  iob_ila_pattern_gen #(
    .SIGNAL_W (32),
    .BUFFER_W (3),
    .TRIGGER_W(2),
    .HOLD_W   (16)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .cke_i      (cke_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .length_i   (length_i),
    .hold_i     (hold_i),
    .loop_i     (loop_i),
    .trigger_i  (trigger_i),
    .trig_mask_i(trig_mask_i),
    .signal_o   (signal_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .index_o    (index_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] len, input logic [15:0] hold,
                          input logic lp, input logic [1:0] msk);
    length_i    = len;
    hold_i      = hold;
    loop_i      = lp;
    trig_mask_i = msk;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o),  32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    arst_i      = 1'b0;
    cke_i       = 1'b1;
    wr_en_i     = 1'b0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    length_i    = '0;
    hold_i      = '0;
    loop_i      = 1'b0;
    trigger_i   = '0;
    trig_mask_i = '0;

    // Reset state
    tick();
    tick();
    check("rst_signal", signal_o, 32'd0);
    check("rst_valid",  32'(valid_o), 32'd0);
    check("rst_busy",   32'(busy_o),  32'd0);
    check("rst_done",   32'(done_o),  32'd0);
    check("rst_index",  32'(index_o), 32'd0);
    @(negedge clk_i);
    arst_i = 1'b1;
    tick();

    // Preload buffer
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = 32'hA0 + 32'(i);
      wr_en_i    = 1'b1;
      wr_addr_i  = 3'(i);
      wr_data_i  = exp_mem[i];
      tick();
    end
    wr_en_i = 1'b0;

    // Single shot, length 4, hold 0
    do_start(4'd4, 16'd0, 1'b0, 2'b00);
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_valid_pre", 32'(valid_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_sig%0d", k), signal_o, 32'hA0 + 32'(k));
      check($sformatf("t1_idx%0d", k), 32'(index_o), 32'(k));
      check($sformatf("t1_val%0d", k), 32'(valid_o), 32'd1);
    end
    tick();
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_valid_end", 32'(valid_o), 32'd0);
    check("t1_busy_end", 32'(busy_o), 32'd0);
    check("t1_sig_hold", signal_o, 32'hA3);

    // Loop, length 3, hold 2
    do_start(4'd3, 16'd2, 1'b1, 2'b00);
    check("t2_done_clr", 32'(done_o), 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("t2_sig%0d", c), signal_o, 32'hA0 + 32'((c / 3) % 3));
      check($sformatf("t2_val%0d", c), 32'(valid_o), 32'd1);
    end
    // Clock enable low freezes playback
    cke_i = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("t2_cke_sig", signal_o, 32'hA0);
    check("t2_cke_busy", 32'(busy_o), 32'd1);
    cke_i  = 1'b1;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check_idle_outs("t2_stop");
    check("t2_stop_done", 32'(done_o), 32'd0);
    check("t2_stop_sig", signal_o, 32'hA0);

    // Masked trigger
    trigger_i = 2'b01;
    do_start(4'd1, 16'd0, 1'b0, 2'b10);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("t3_armed_busy%0d", c), 32'(busy_o), 32'd1);
      check($sformatf("t3_armed_val%0d", c), 32'(valid_o), 32'd0);
    end
    trigger_i = 2'b10;
    tick();
    trigger_i = 2'b00;
    check("t3_play_val", 32'(valid_o), 32'd0);
    tick();
    check("t3_sig", signal_o, 32'hA0);
    check("t3_val", 32'(valid_o), 32'd1);
    tick();
    check("t3_done", 32'(done_o), 32'd1);

    // Illegal lengths and start+stop
    do_start(4'd0, 16'd0, 1'b0, 2'b00);
    check("t4_len0_busy", 32'(busy_o), 32'd0);
    check("t4_len0_done", 32'(done_o), 32'd1);
    do_start(4'd9, 16'd0, 1'b0, 2'b00);
    check("t4_len9_busy", 32'(busy_o), 32'd0);
    length_i = 4'd4;
    start_i  = 1'b1;
    stop_i   = 1'b1;
    tick();
    start_i  = 1'b0;
    stop_i   = 1'b0;
    check_idle_outs("t4_ss");
    check("t4_ss_done", 32'(done_o), 32'd0);
    tick();
    check("t4_ss_busy2", 32'(busy_o), 32'd0);

    // Rewrite during loop playback
    do_start(4'd8, 16'd0, 1'b1, 2'b00);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (valid_o && index_o == 3'd2) found = 1'b1;
    end
    check("t5_wait_idx2", 32'(found), 32'd1);
    exp_mem[5] = 32'h55;
    wr_en_i    = 1'b1;
    wr_addr_i  = 3'd5;
    wr_data_i  = 32'h55;
    tick();
    wr_en_i    = 1'b0;
    check("t5_idx3", 32'(index_o), 32'd3);
    tick();
    tick();
    check("t5_idx5", 32'(index_o), 32'd5);
    check("t5_sig5", signal_o, 32'h55);
    for (int c = 0; c < 8; c++) tick();
    check("t5_idx5b", 32'(index_o), 32'd5);
    check("t5_sig5b", signal_o, 32'h55);

    // Async reset mid-play, then replay
    tick();
    #2;
    arst_i = 1'b0;
    #1;
    check("t6_rst_sig",   signal_o, 32'd0);
    check("t6_rst_valid", 32'(valid_o), 32'd0);
    check("t6_rst_busy",  32'(busy_o), 32'd0);
    check("t6_rst_done",  32'(done_o), 32'd0);
    check("t6_rst_idx",   32'(index_o), 32'd0);
    @(negedge clk_i);
    arst_i = 1'b1;
    tick();
    do_start(4'd8, 16'd0, 1'b0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t6_sig%0d", k), signal_o, exp_mem[k]);
    end
    tick();
    check("t6_done", 32'(done_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
